// File: rtl/ray_generator_pkg.sv
// Shared vec3 types, Q2.16 constants and generator state encoding for the ray pipeline.
package ray_generator_pkg;

  localparam int unsigned CompW = 18;

  typedef logic signed [CompW-1:0] comp_t;

  typedef struct packed {
    comp_t x;
    comp_t y;
    comp_t z;
  } vec3_t;

  localparam comp_t ONE = 18'sh10000;
  localparam comp_t EPS = 18'sd1;

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StDone
  } state_e;

  // Nudges exact-zero components off zero so a reciprocal stage never sees 0.
  function automatic vec3_t zero_guard(input vec3_t v);
    vec3_t r;
    r = v;
    if (v.x == '0) r.x = EPS;
    if (v.y == '0) r.y = EPS;
    if (v.z == '0) r.z = EPS;
    return r;
  endfunction

endpackage

// File: rtl/ray_generator_if.sv
// Camera-in / ray-out bundle of the primary-ray generator.
interface ray_generator_if
  import ray_generator_pkg::*;
#(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240
);
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic          start;
  logic          stall;
  vec3_t         cam_origin;
  vec3_t         cam_dir00;
  vec3_t         cam_du;
  vec3_t         cam_dv;
  logic          ray_valid;
  vec3_t         ray_dir;
  vec3_t         ray_origin;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic          last;
  logic          busy;
  logic          done;

  modport master (
    output start, stall, cam_origin, cam_dir00, cam_du, cam_dv,
    input  ray_valid, ray_dir, ray_origin, pixel_x, pixel_y, last, busy, done
  );

  modport slave (
    input  start, stall, cam_origin, cam_dir00, cam_du, cam_dv,
    output ray_valid, ray_dir, ray_origin, pixel_x, pixel_y, last, busy, done
  );

endinterface

// File: rtl/vec3_add.sv
// Combinational per-component 18-bit two's-complement wrap adder.
module vec3_add
  import ray_generator_pkg::*;
(
  input  vec3_t a_i,
  input  vec3_t b_i,
  output vec3_t sum_o
);

  assign sum_o.x = a_i.x + b_i.x;
  assign sum_o.y = a_i.y + b_i.y;
  assign sum_o.z = a_i.z + b_i.z;

endmodule

// File: rtl/ray_generator.sv
// Raster-order primary-ray generator using incremental direction stepping.
// Optional RAY_GEN_ZERO_GUARD_EN replaces zero emitted direction components with +1 LSB.
module ray_generator
  import ray_generator_pkg::*;
#(
  parameter int unsigned IMG_W = 320,
  parameter int unsigned IMG_H = 240
) (
  input logic            clk,
  input logic            rst,
  ray_generator_if.slave bus
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0] XLast = XW'(IMG_W - 1);
  localparam logic [YW-1:0] YLast = YW'(IMG_H - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  vec3_t         dir_q, dir_d;
  vec3_t         row_q, row_d;
  vec3_t         origin_q, origin_d;
  vec3_t         du_q, du_d;
  vec3_t         dv_q, dv_d;
  vec3_t         col_sum, row_sum;

  vec3_add u_col_add (
    .a_i  (dir_q),
    .b_i  (du_q),
    .sum_o(col_sum)
  );

  vec3_add u_row_add (
    .a_i  (row_q),
    .b_i  (dv_q),
    .sum_o(row_sum)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    row_d    = row_q;
    origin_d = origin_q;
    du_d     = du_q;
    dv_d     = dv_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start && !bus.stall) begin
          origin_d = bus.cam_origin;
          du_d     = bus.cam_du;
          dv_d     = bus.cam_dv;
          dir_d    = bus.cam_dir00;
          row_d    = bus.cam_dir00;
          x_d      = '0;
          y_d      = '0;
          state_d  = StGen;
        end
      end
      StGen: begin
        if (!bus.stall) begin
          if (x_q != XLast) begin
            x_d   = x_q + XW'(1);
            dir_d = col_sum;
          end else begin
            // Row wrap restarts from the row base so column error never accumulates.
            x_d   = '0;
            y_d   = y_q + YW'(1);
            row_d = row_sum;
            dir_d = row_sum;
            if (y_q == YLast) state_d = StDone;
          end
        end
      end
      StDone: begin
        if (!bus.stall) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      x_q      <= '0;
      y_q      <= '0;
      dir_q    <= '0;
      row_q    <= '0;
      origin_q <= '0;
      du_q     <= '0;
      dv_q     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      row_q    <= row_d;
      origin_q <= origin_d;
      du_q     <= du_d;
      dv_q     <= dv_d;
    end
  end

  assign bus.ray_valid  = (state_q == StGen);
  assign bus.busy       = (state_q == StGen);
  assign bus.done       = (state_q == StDone);
  assign bus.last       = (state_q == StGen) && (x_q == XLast) && (y_q == YLast);
  assign bus.ray_origin = origin_q;
  assign bus.pixel_x    = x_q;
  assign bus.pixel_y    = y_q;

`ifdef RAY_GEN_ZERO_GUARD_EN
  assign bus.ray_dir = (state_q == StGen) ? zero_guard(dir_q) : dir_q;
`else
  assign bus.ray_dir = dir_q;
`endif

endmodule

// File: tb/tb_ray_generator.sv
// Self-checking bench for ray_generator: directed frames with random cameras vs. closed-form model.
module tb_ray_generator;
  import ray_generator_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned H = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  vec3_t m_origin, m_dir00, m_du, m_dv;

  always #5 clk = ~clk;

  ray_generator_if #(.IMG_W(W), .IMG_H(H)) bus ();

  ray_generator #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed form: dir(px,py) = dir00 + px*du + py*dv, wrapped to 18 bits.
  function automatic comp_t mc(input comp_t a, input comp_t b, input comp_t c,
                               input int px, input int py);
    int s;
    s = int'(a) + px * int'(b) + py * int'(c);
    return comp_t'(s);
  endfunction

  function automatic vec3_t exp_dir(input int px, input int py);
    vec3_t r;
    r.x = mc(m_dir00.x, m_du.x, m_dv.x, px, py);
    r.y = mc(m_dir00.y, m_du.y, m_dv.y, px, py);
    r.z = mc(m_dir00.z, m_du.z, m_dv.z, px, py);
`ifdef RAY_GEN_ZERO_GUARD_EN
    if (r.x == 0) r.x = 18'sd1;
    if (r.y == 0) r.y = 18'sd1;
    if (r.z == 0) r.z = 18'sd1;
`endif
    return r;
  endfunction

  function automatic vec3_t rnd_vec();
    vec3_t r;
    r.x = comp_t'($urandom);
    r.y = comp_t'($urandom);
    r.z = comp_t'($urandom);
    return r;
  endfunction

  task automatic rnd_cam();
    bus.cam_origin = rnd_vec();
    bus.cam_dir00  = rnd_vec();
    bus.cam_du     = rnd_vec();
    bus.cam_dv     = rnd_vec();
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, ".valid"}, 64'(bus.ray_valid), 64'(0));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(0));
    chk({tag, ".done"}, 64'(bus.done), 64'(0));
    chk({tag, ".last"}, 64'(bus.last), 64'(0));
    chk({tag, ".dir"}, 64'(bus.ray_dir), 64'(0));
    chk({tag, ".origin"}, 64'(bus.ray_origin), 64'(0));
    chk({tag, ".px"}, 64'(bus.pixel_x), 64'(0));
    chk({tag, ".py"}, 64'(bus.pixel_y), 64'(0));
  endtask

  task automatic check_pixel(input int px, input int py);
    string t;
    t = $sformatf("pix(%0d,%0d)", px, py);
    chk({t, ".valid"}, 64'(bus.ray_valid), 64'(1));
    chk({t, ".busy"}, 64'(bus.busy), 64'(1));
    chk({t, ".done"}, 64'(bus.done), 64'(0));
    chk({t, ".px"}, 64'(bus.pixel_x), 64'(px));
    chk({t, ".py"}, 64'(bus.pixel_y), 64'(py));
    chk({t, ".dir"}, 64'(bus.ray_dir), 64'(exp_dir(px, py)));
    chk({t, ".origin"}, 64'(bus.ray_origin), 64'(m_origin));
    chk({t, ".last"}, 64'(bus.last), 64'((px == W - 1) && (py == H - 1)));
  endtask

  // Called at a negedge with camera inputs set; returns at a negedge in IDLE.
  task automatic run_frame(input int stall_idx, input int stall_len, input int mid_start_idx,
                           input int abort_idx, input bit done_stall, input bit start_in_done);
    int px, py;
    bus.start = 1'b1;
    m_origin  = bus.cam_origin;
    m_dir00   = bus.cam_dir00;
    m_du      = bus.cam_du;
    m_dv      = bus.cam_dv;
    @(negedge clk);
    bus.start = 1'b0;
    rnd_cam();
    for (int i = 0; i < W * H; i++) begin
      px = i % W;
      py = i / W;
      check_pixel(px, py);
      if (i == abort_idx) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("abort");
        @(negedge clk);
        chk("abort.no_done", 64'(bus.done), 64'(0));
        chk("abort.idle", 64'(bus.ray_valid), 64'(0));
        return;
      end
      if (i == stall_idx) begin
        bus.stall = 1'b1;
        repeat (stall_len) begin
          @(negedge clk);
          check_pixel(px, py);
        end
        bus.stall = 1'b0;
      end
      if (i == mid_start_idx) bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("done.pulse", 64'(bus.done), 64'(1));
    chk("done.valid", 64'(bus.ray_valid), 64'(0));
    chk("done.busy", 64'(bus.busy), 64'(0));
    chk("done.last", 64'(bus.last), 64'(0));
    if (done_stall) begin
      bus.stall = 1'b1;
      repeat (2) begin
        @(negedge clk);
        chk("done.held", 64'(bus.done), 64'(1));
      end
      bus.stall = 1'b0;
    end
    if (start_in_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("post.done", 64'(bus.done), 64'(0));
    chk("post.valid", 64'(bus.ray_valid), 64'(0));
    chk("post.busy", 64'(bus.busy), 64'(0));
  endtask

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stall      = 1'b0;
    bus.cam_origin = '0;
    bus.cam_dir00  = '0;
    bus.cam_du     = '0;
    bus.cam_dv     = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("idle");

    // Frame walk; a start during the done cycle must be ignored.
    bus.cam_origin = rnd_vec();
    bus.cam_dir00  = '{x: 18'sd0, y: 18'sd0, z: ONE};
    bus.cam_du     = '{x: 18'sh04000, y: 18'sd0, z: 18'sd0};
    bus.cam_dv     = '{x: 18'sd0, y: 18'sh04000, z: 18'sd0};
    run_frame(-1, 0, -1, -1, 1'b0, 1'b1);

    // Restart one cycle after done; stall at (1,0), mid-frame start, stall in done.
    rnd_cam();
    run_frame(1, 5, 4, -1, 1'b1, 1'b0);

    // Positive-to-negative wrap on x.
    rnd_cam();
    bus.cam_dir00.x = 18'sh1FFFF;
    bus.cam_du.x    = 18'sd1;
    run_frame(-1, 0, -1, -1, 1'b0, 1'b0);

    // Reset at pixel (2,1), then a full frame from (0,0).
    rnd_cam();
    run_frame(-1, 0, -1, 6, 1'b0, 1'b0);
    rnd_cam();
    run_frame(-1, 0, -1, -1, 1'b0, 1'b0);

    // Reset and start together: reset wins.
    rnd_cam();
    rst       = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    check_idle_zero("rst_start");
    @(negedge clk);
    chk("rst_start.idle", 64'(bus.ray_valid), 64'(0));

    // Zero components in the direction field.
    bus.cam_origin = rnd_vec();
    bus.cam_dir00  = '{x: 18'sd0, y: 18'sd0, z: ONE};
    bus.cam_du     = '0;
    bus.cam_dv     = '0;
    run_frame(-1, 0, -1, -1, 1'b0, 1'b0);

    for (int f = 0; f < 3; f++) begin
      rnd_cam();
      run_frame(int'($urandom_range(0, W * H - 1)), int'($urandom_range(1, 4)), -1, -1,
                1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ray_generator.md
# ray_generator

Primary-ray generator at the head of the ray pipeline. On a start pulse it latches a camera description and emits one ray per pixel in raster order, one per non-stalled cycle. Directions are formed incrementally, by adding per-pixel and per-row step vectors, so no multipliers are needed. Its `ray_dir` output feeds the ray direction-inverse stage directly and shares that stage's `stall`.

## Interface
Parameters:
- `IMG_W`, default 320: pixels per row (≥2).
- `IMG_H`, default 240: rows per frame (≥2).

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: frame start pulse; only honoured in IDLE.
- `stall`, in, 1: downstream hold; the same signal drives the inverse stage's clock enable as `~stall`.
- `cam_origin`, in, vec3: ray origin shared by all pixels.
- `cam_dir00`, in, vec3: direction of pixel (0,0).
- `cam_du`, in, vec3: per-column direction step.
- `cam_dv`, in, vec3: per-row direction step.
- `ray_valid`, out, 1: `ray_dir`, `ray_origin` and pixel coordinates are valid.
- `ray_dir`, out, vec3: current ray direction.
- `ray_origin`, out, vec3: latched `cam_origin`.
- `pixel_x`, out, $clog2(IMG_W): column index.
- `pixel_y`, out, $clog2(IMG_H): row index.
- `last`, out, 1: asserted with the final pixel of the frame.
- `busy`, out, 1: high in GEN.
- `done`, out, 1: one-cycle pulse after the final ray.

## Operation
- vec3 components are signed 18-bit Q2.16. All adds are per component, two's-complement, 18-bit, and wrap on overflow with no saturation.
- State machine:
  - IDLE: `start` latches the four camera inputs, sets `ray_dir` to `cam_dir00`, sets x and y to 0, and moves to GEN.
  - GEN, each cycle with `stall`=0:
    - If x<IMG_W-1: x+=1 and `ray_dir`+=`du`.
    - Otherwise x=0, y+=1, `row_base`+=`dv`, and `ray_dir`=`row_base`+`dv`.
    - When the ray at (IMG_W-1, IMG_H-1) is accepted, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- A ray is accepted on any GEN cycle with `stall`=0.
- With `stall`=1, the state, counters, accumulators and every output hold their values, including `done` while in DONE.
- `start` is ignored outside IDLE. Camera inputs may change freely after the latch.
- `last`=1 exactly when `ray_valid`=1 and x=IMG_W-1 and y=IMG_H-1.

## Timing
- Reset, whether mid-frame or not, forces the following on the next edge. Any in-flight frame is abandoned; no `done`.
  - state=IDLE.
  - `ray_valid`, `busy`, `done`, `last` = 0.
  - `ray_dir`, `ray_origin` = 0.
  - `pixel_x`, `pixel_y` = 0.
- Start latency:
  - `start` sampled high in cycle N, in IDLE.
  - Cycle N+1: `ray_valid`=1 with pixel (0,0).
- Throughput: one ray per non-stalled cycle.
- A frame takes IMG_W·IMG_H accepted cycles, then one DONE cycle.
- `start` in the `done` cycle is ignored. The earliest restart is the following cycle.
- `rst` and `start` asserted in the same cycle: reset wins.

## Configuration
- `RAY_GEN_ZERO_GUARD_EN` defined: any emitted `ray_dir` component equal to 0 is replaced by +1 LSB (18'sd1). This keeps the downstream divider from flagging divide-by-zero. The internal accumulators stay unmodified.
- Not defined: components pass through unchanged, and zero components reach the divider.

## Structure
- vec3, Q2.16 constants (`ONE`, `EPS` = 1 LSB) and the state enum live in the shared data package alongside the existing vec3 definitions.
- One natural sub-module, `vec3_add`: a combinational per-component 18-bit wrap adder, instantiated for the column and row paths.

## Test plan
Use IMG_W=4, IMG_H=3 throughout.
- Frame walk: dir00=(0,0,1.0), du=(0.25,0,0), dv=(0,0.25,0), start once. Expect 12 rays in raster order; pixel (3,2) has dir (0.75,0.5,1.0) with `last`=1; `done` one cycle later.
- Stall: hold `stall` high for 5 cycles at pixel (1,0). Outputs stay frozen at (1,0), and no pixel is skipped or repeated after release.
- Wrap: dir00.x=18'h1FFFF, du.x=1. Pixel (1,0) has x=18'h20000 (wrapped negative).
- Start handling: pulse `start` mid-frame and it has no effect. A `start` in the `done` cycle is ignored; a `start` one cycle after `done` begins a new frame on the next cycle.
- Reset mid-frame at pixel (2,1): all outputs are 0 on the next edge, no `done`, and a new start resumes from (0,0).
- Zero guard with macro defined: du=0, dir00=(0,0,1.0). Emitted dir=(1 LSB, 1 LSB, 1.0). Without the macro: (0,0,1.0).
